// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared CPU constants and loader state encoding.
package instr_loader_pkg;
    localparam int INSTR_W = 19;
    typedef enum logic [2:0] {IDLE, B0, B1, B2, WRITE, CHECK, DONE} state_t;
endpackage

// File: rtl/instr_loader.sv
// instr_loader: assembles a little-endian byte stream into 19-bit words and writes instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W:0]    word_count,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               cpu_rst,
    output logic               busy,
    output logic               done,
    output logic               error
);
    state_t state, nxt;
    logic [ADDR_W:0] remaining;
    logic xfer, accept, last;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif
    assign xfer = s_valid && s_ready;
    assign accept = start && (state == IDLE || state == DONE);
    assign last = remaining == (ADDR_W+1)'(1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = accept ? (word_count == '0 ? DONE : B0) : state;
            B0:         nxt = xfer ? B1 : B0;
            B1:         nxt = xfer ? B2 : B1;
            B2:         nxt = xfer ? WRITE : B2;
`ifdef LOADER_CHECKSUM_EN
            WRITE:      nxt = last ? CHECK : B0;
            CHECK:      nxt = xfer ? DONE : CHECK;
`else
            WRITE:      nxt = last ? DONE : B0;
`endif
            default:    nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_ready   <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            remaining <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state   <= nxt;
            s_ready <= nxt inside {B0, B1, B2, CHECK};
            im_we   <= nxt == WRITE;
            busy    <= !(nxt inside {IDLE, DONE});
            done    <= nxt == DONE;
            cpu_rst <= nxt != DONE;
            if (accept) begin
                remaining <= word_count;
                im_addr   <= '0;
                error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                csum      <= '0;
`endif
            end
            if (xfer && state == B0) im_wdata[7:0] <= s_data;
            if (xfer && state == B1) im_wdata[15:8] <= s_data;
            if (xfer && state == B2) begin
                im_wdata[18:16] <= s_data[2:0];
                if (s_data[7:3] != '0) error <= 1'b1;
            end
            if (state == WRITE) begin
                remaining <= remaining - 1'b1;
                if (!last) im_addr <= im_addr + 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            if (xfer && state != CHECK) csum <= csum ^ s_data;
            if (xfer && state == CHECK && s_data != csum) error <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader; expected writes are queued as bytes are driven.
module tb_instr_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst, start, s_valid;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        s_data;
    logic              s_ready, im_we, cpu_rst, busy, done, error;
    logic [ADDR_W-1:0] im_addr;
    logic [18:0]       im_wdata;

    int total = 0;
    int bad = 0;
    logic [ADDR_W+18:0] sb[$];

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%0h data=%0h with nothing expected", im_addr, im_wdata);
            end else begin
                logic [ADDR_W+18:0] e;
                e = sb.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    bad++;
                    $display("FAIL write: got addr=%0h data=%0h want addr=%0h data=%0h",
                             im_addr, im_wdata, e[ADDR_W+18:19], e[18:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        @(negedge clk);
        if (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data = b;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL s_ready_timeout: s_ready=%b want 1", s_ready);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, b1, b2, input logic [ADDR_W-1:0] a, input bit gap);
        sb.push_back({a, b2[2:0], b1, b0});
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
    endtask

    task automatic start_load(input logic [ADDR_W:0] n);
        @(negedge clk);
        start = 1'b1;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_load(input string name, input logic exp_err);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!done || cpu_rst || busy) begin
            bad++;
            $display("FAIL %s_done: done=%b cpu_rst=%b busy=%b want 1 0 0", name, done, cpu_rst, busy);
        end
        total++;
        if (error !== exp_err) begin
            bad++;
            $display("FAIL %s_error: error=%b want %b", name, error, exp_err);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_writes: pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1 || s_ready !== 1'b0 ||
            im_we !== 1'b0 || im_addr !== '0 || im_wdata !== '0 || error !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%b done=%b cpu_rst=%b s_ready=%b im_we=%b addr=%0h wdata=%0h error=%b want 0 0 1 0 0 0 0 0",
                     name, busy, done, cpu_rst, s_ready, im_we, im_addr, im_wdata, error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");
    endtask

    task automatic run_basic(input string name, input bit gap, input logic [7:0] ck, input logic exp_err);
        start_load(2);
        send_word(8'h34, 8'h12, 8'h05, 0, gap);
        send_word(8'hFF, 8'hFF, 8'h07, 1, gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(ck, gap);
`else
        if (ck != 8'h24) exp_err = 1'b0;
`endif
        finish_load(name, exp_err);
    endtask

    task automatic test_basic();
        run_basic("basic", 1'b0, 8'h24, 1'b0);
    endtask

    task automatic test_toggle();
        run_basic("toggle", 1'b1, 8'h24, 1'b0);
    endtask

    task automatic test_checksum_bad();
        run_basic("csum_bad", 1'b0, 8'h25, 1'b1);
    endtask

    task automatic test_bad_b2();
        start_load(1);
        send_word(8'h00, 8'h00, 8'h0D, 0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h0D, 1'b0);
`endif
        finish_load("bad_b2", 1'b1);
    endtask

    task automatic test_mid_reset();
        start_load(2);
        send_word(8'h34, 8'h12, 8'h05, 0, 1'b0);
        send_byte(8'hFF, 1'b0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_load_busy: busy=%b s_ready=%b want 1 1", busy, s_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_reset");
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL mid_reset_writes: pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_zero_count();
        start_load(0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL zero_count: done=%b busy=%b cpu_rst=%b error=%b want 1 0 0 0", done, busy, cpu_rst, error);
        end
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL zero_count_hold: done=%b want 1", done);
        end
    endtask

    task automatic test_start_ignored();
        start_load(1);
        start_load(2);
        send_word(8'hAA, 8'h55, 8'h03, 0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hAA ^ 8'h55 ^ 8'h03, 1'b0);
`endif
        finish_load("start_ignored", 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        word_count = '0;
        test_reset();
        test_basic();
        test_toggle();
        test_bad_b2();
        test_basic();
`ifdef LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        test_mid_reset();
        test_zero_count();
        test_start_ignored();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: instruction-memory address width; the memory holds 2^ADDR_W words.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1: one-cycle request to begin a load.
REQ-005 SHALL have port word_count  input  ADDR_W+1: number of 19-bit words to load, sampled on an accepted start.
REQ-006 SHALL have port s_data  input  8: byte stream data.
REQ-007 SHALL have port s_valid  input  1: s_data valid.
REQ-008 SHALL have port s_ready  output  1: loader accepts a byte this cycle.
REQ-009 SHALL have port im_we  output  1: instruction-memory write strobe.
REQ-010 SHALL have port im_addr  output  ADDR_W: instruction-memory write address.
REQ-011 SHALL have port im_wdata  output  19: instruction word to write.
REQ-012 SHALL have port cpu_rst  output  1: active-high reset holding the CPU while the program is not loaded.
REQ-013 SHALL have ports busy, done, error  output  1 each: status flags.

Function
REQ-014 SHALL implement states IDLE, B0, B1, B2, WRITE, CHECK, DONE.
REQ-015 SHALL, in IDLE or DONE, accept start: go to DONE next cycle if word_count==0, else go to B0; latch word_count; clear im_addr, error and the checksum accumulator.
REQ-016 SHALL ignore start in all other states.
REQ-017 SHALL assert s_ready only in B0, B1, B2 and CHECK; a byte transfers on a cycle with s_valid && s_ready.
REQ-018 SHALL, per word in little-endian order: B0 byte -> word[7:0]; B1 byte -> word[15:8]; B2 byte bits[2:0] -> word[18:16]; advance one state per transferred byte.
REQ-019 SHALL set error (sticky) if B2 byte bits[7:3] != 0, and still write the word.
REQ-020 SHALL, in WRITE (the cycle after the B2 transfer), assert im_we for exactly one cycle with im_addr/im_wdata stable.
REQ-021 SHALL then increment im_addr and go to B0 if words remain; otherwise go to CHECK (checksum enabled) or DONE.
REQ-022 SHALL wrap im_addr modulo 2^ADDR_W when word_count == 2^ADDR_W.
REQ-023 SHALL drive busy=1 in every state except IDLE and DONE, and done=1 only in DONE.
REQ-024 SHALL drive cpu_rst=1 in every state except DONE.
REQ-025 SHALL hold state indefinitely while s_valid is low (no timeout).

Reset
REQ-026 SHALL on rst, including mid-load: state=IDLE, im_we=0, im_addr=0, im_wdata=0, s_ready=0, busy=0, done=0, error=0, cpu_rst=1, checksum=0; partially assembled words are discarded.

Configuration
REQ-027 SHALL, with LOADER_CHECKSUM_EN defined: XOR-accumulate every data byte; in CHECK accept one extra byte; set error if it differs from the accumulator; then go to DONE.
REQ-028 SHALL, without LOADER_CHECKSUM_EN: omit the CHECK state and the accumulator, going from the last WRITE straight to DONE.

Structure
REQ-029 SHALL take the 19-bit instruction width constant and the state enum typedef from the shared CPU package.
REQ-030 SHALL be a single module with no sub-modules; byte assembly and the FSM live together.

Verification
REQ-031 SHALL verify: word_count=2, bytes 34,12,05,FF,FF,07 -> im_we at addr0=0x51234 and addr1=0x7FFFF, then done=1, cpu_rst=0.
REQ-032 SHALL verify: the same stream with s_valid toggling every other cycle -> identical writes, with no byte lost or duplicated.
REQ-033 SHALL verify: a B2 byte of 0x0D -> word[18:16]=5 written and error=1 at DONE.
REQ-034 SHALL verify, with LOADER_CHECKSUM_EN: the REQ-031 stream plus 0x24 -> error=0; plus 0x25 -> error=1.
REQ-035 SHALL verify: rst after 4 bytes -> next cycle IDLE, im_addr=0, im_we=0, cpu_rst=1, done=0.
REQ-036 SHALL verify: word_count=0 with start -> DONE next cycle with no im_we pulses.
